segre_mem_arbiter: RTL
======================

Name: segre_mem_arbiter

Overview:
Parametrised arbiter that gives NUM_PORTS pipeline requestors (IF, MEM data cache, store buffer, future prefetcher) shared access to the single cache-line memory port. It replaces the hard-wired two-way select at core top. Supports round-robin or fixed-priority arbitration. Latches the winning request, holds it stable on the memory side until mem_ready_i, then routes the response back to the granted port only.

Parameters:
NUM_PORTS, 2, number of requestors (>=1)
ADDR_W, ADDR_SIZE, address width
LINE_BYTES, CACHE_LINE_SIZE_BYTES, bytes per transferred line
ARB_MODE, ARB_RR, arb_mode_e; ARB_RR = round-robin, ARB_FIXED = port 0 highest priority
TIMEOUT_CYCLES, 0, busy-cycle limit before timeout_o; 0 disables the check

Ports:
clk_i  in  1  clock
rsn_i  in  1  reset, synchronous, active-low
req_rd_i  in  [NUM_PORTS]  per-port read request
req_wr_i  in  [NUM_PORTS]  per-port write request
req_addr_i  in  [NUM_PORTS][ADDR_W]  per-port address
req_data_type_i  in  [NUM_PORTS] memop_data_type_e  per-port access size
req_wr_data_i  in  [NUM_PORTS][LINE_BYTES][8]  per-port write line
req_ready_o  out  [NUM_PORTS]  completion strobe to the granted port
req_rd_data_o  out  [LINE_BYTES][8]  read line; valid only when a req_ready_o bit is high
grant_o  out  [NUM_PORTS]  one-hot owner of the current transaction
busy_o  out  1  transaction in flight
timeout_o  out  1  sticky timeout flag
mem_addr_o  out  ADDR_W  to memory
mem_rd_o  out  1  to memory
mem_wr_o  out  1  to memory
mem_data_type_o  out  memop_data_type_e  to memory
mem_wr_data_o  out  [LINE_BYTES][8]  to memory
mem_rd_data_i  in  [LINE_BYTES][8]  from memory
mem_ready_i  in  1  memory completion

Behaviour:
- FSM has two states, IDLE and BUSY. A port is requesting when req_rd_i|req_wr_i.
- IDLE: if any port is requesting, pick winner g. At the clock edge, latch g's addr, type, wr data and rd/wr into output registers, set grant_o=1<<g, and go to BUSY.
- Latency: mem_rd_o/mem_wr_o rise exactly 1 cycle after the request is first seen in IDLE.
- If rd and wr are both set on the winner, the write wins: mem_wr_o=1, mem_rd_o=0.
- BUSY: memory-side outputs are held constant.
  - req_ready_o[g] = mem_ready_i, combinational, for that cycle only. All other bits of req_ready_o are 0.
  - req_rd_data_o = mem_rd_data_i (pass-through).
  - On mem_ready_i: next state is IDLE, mem_rd_o/mem_wr_o/grant_o clear, and the RR pointer becomes (g+1) mod NUM_PORTS.
- IDLE after a completion is mandatory for one cycle, so the finishing requestor can drop its request. No back-to-back grant occurs in the completion cycle.
- Round-robin search order: ptr, ptr+1, ..., wrapping modulo NUM_PORTS. ARB_FIXED: lowest index wins and the pointer is ignored.
- Requestors keep req asserted until their req_ready_o. A request dropped while BUSY does not abort; the transaction completes and req_ready_o still pulses.
- Memory outputs mem_rd_o/mem_wr_o are 0 whenever state is IDLE. mem_ready_i in IDLE is ignored.
- Timeout: a counter of BUSY cycles without ready, saturating. When it reaches TIMEOUT_CYCLES (>0), timeout_o sets and stays set until reset. The FSM keeps waiting in BUSY.
- Reset, including in the middle of a transaction: state IDLE, RR pointer 0, counter 0. All outputs 0: grant_o, req_ready_o, busy_o, timeout_o, mem_rd_o, mem_wr_o, mem_addr_o, mem_wr_data_o, and mem_data_type_o=WORD.
- busy_o = (state==BUSY).

Decomposition:
- segre_pkg gains the typedef arb_mode_e {ARB_RR, ARB_FIXED}. memop_data_type_e, ADDR_SIZE and CACHE_LINE_SIZE_BYTES are reused from it.
- Sub-module segre_rr_picker: combinational one-hot picker, with inputs req vector, pointer and mode and output a one-hot grant. It is instantiated once.
- FSM, latches and timeout counter live in segre_mem_arbiter.

Test Plan:
1. NUM_PORTS=2, port0 reads 0x100 at cycle 0 -> mem_rd_o=1 and mem_addr_o=0x100 at cycle 1; mem_ready_i at cycle 3 with data 0xA5.. -> req_ready_o=2'b01 and req_rd_data_o=0xA5.. at cycle 3; busy_o=0 at cycle 4.
2. ARB_RR, both ports request continuously, memory readies 1 cycle after issue -> grant sequence 01,10,01,10 with one IDLE cycle between grants.
3. ARB_FIXED, same stimulus -> port0 granted every time; port1 never gets req_ready_o.
4. NUM_PORTS=3, pointer=2 (after a port1 grant), ports 0 and 1 request -> grant_o=3'b001.
5. Port1 write with rd also set, addr 0x40 -> mem_wr_o=1, mem_rd_o=0, mem_wr_data_o equals port1 data.
6. Port0 drops its request 1 cycle after grant -> memory-side outputs unchanged, req_ready_o[0] still pulses on mem_ready_i.
7. Reset asserted in BUSY -> next cycle all outputs 0 and state IDLE; a later mem_ready_i pulse is ignored.
8. TIMEOUT_CYCLES=8, no mem_ready_i -> timeout_o=1 after the 8th BUSY cycle and stays 1; a later ready completes normally.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared core definitions: memory op sizes, address/line geometry and
// the arbitration mode selector used by the memory-port arbiter.
package segre_pkg;

  localparam int ADDR_SIZE             = 32;
  localparam int CACHE_LINE_SIZE_BYTES = 16;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Pointer width that stays legal for a single requestor.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/segre_rr_picker.sv
// Combinational one-hot picker: round-robin starting at ptr, or fixed
// priority with index 0 highest.
module segre_rr_picker
  import segre_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = ptr_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  input  arb_mode_e            mode,
  output logic [NUM_PORTS-1:0] grant
);

  logic [PTR_W-1:0]       start;
  logic [2*NUM_PORTS-1:0] dbl_req;
  logic [2*NUM_PORTS-1:0] dbl_gnt;
  logic [NUM_PORTS-1:0]   rot_req;
  logic [NUM_PORTS-1:0]   rot_gnt;

  // Rotate so the search origin sits at bit 0, take the lowest set bit,
  // then rotate the one-hot result back into port order.
  always_comb begin
    if (mode == ARB_FIXED) begin
      start = '0;
    end else begin
      start = ptr;
    end
    dbl_req = {req, req} >> start;
    rot_req = dbl_req[NUM_PORTS-1:0];
    rot_gnt = rot_req & (~rot_req + NUM_PORTS'(1'b1));
    dbl_gnt = {rot_gnt, rot_gnt} << start;
    grant   = dbl_gnt[2*NUM_PORTS-1:NUM_PORTS];
  end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Shares the single cache-line memory port among NUM_PORTS requestors:
// latches the winner, holds it until mem_ready_i, routes the response back.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int        NUM_PORTS      = 2,
  parameter int        ADDR_W         = ADDR_SIZE,
  parameter int        LINE_BYTES     = CACHE_LINE_SIZE_BYTES,
  parameter arb_mode_e ARB_MODE       = ARB_RR,
  parameter int        TIMEOUT_CYCLES = 0
) (
  input  logic                                   clk_i,
  input  logic                                   rsn_i,
  input  logic [NUM_PORTS-1:0]                   req_rd_i,
  input  logic [NUM_PORTS-1:0]                   req_wr_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]       req_addr_i,
  input  memop_data_type_e [NUM_PORTS-1:0]       req_data_type_i,
  input  logic [NUM_PORTS-1:0][LINE_BYTES-1:0][7:0] req_wr_data_i,
  output logic [NUM_PORTS-1:0]                   req_ready_o,
  output logic [LINE_BYTES-1:0][7:0]             req_rd_data_o,
  output logic [NUM_PORTS-1:0]                   grant_o,
  output logic                                   busy_o,
  output logic                                   timeout_o,
  output logic [ADDR_W-1:0]                      mem_addr_o,
  output logic                                   mem_rd_o,
  output logic                                   mem_wr_o,
  output memop_data_type_e                       mem_data_type_o,
  output logic [LINE_BYTES-1:0][7:0]             mem_wr_data_o,
  input  logic [LINE_BYTES-1:0][7:0]             mem_rd_data_i,
  input  logic                                   mem_ready_i
);

  localparam int   PTR_W  = ptr_width(NUM_PORTS);
  localparam int   TYPE_W = $bits(memop_data_type_e);
  localparam int   LINE_W = LINE_BYTES * 8;
  localparam int   CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e                    state_r, state_nxt;
  logic [PTR_W-1:0]          ptr_r, ptr_nxt;
  logic [CNT_W-1:0]          cnt_r, cnt_nxt;
  logic                      timeout_r, timeout_nxt;
  logic [NUM_PORTS-1:0]      grant_r, grant_nxt;
  logic [ADDR_W-1:0]         addr_r, addr_nxt;
  logic                      rd_r, rd_nxt;
  logic                      wr_r, wr_nxt;
  memop_data_type_e          type_r, type_nxt;
  logic [LINE_BYTES-1:0][7:0] wdata_r, wdata_nxt;

  logic [NUM_PORTS-1:0]      requesting;
  logic [NUM_PORTS-1:0]      pick;
  logic [ADDR_W-1:0]         sel_addr;
  logic [TYPE_W-1:0]         sel_type;
  logic [LINE_W-1:0]         sel_wdata;
  logic                      sel_rd;
  logic                      sel_wr;
  logic [PTR_W-1:0]          g_idx;
  logic [PTR_W-1:0]          ptr_after;

  assign requesting = req_rd_i | req_wr_i;

  segre_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_picker (
    .req   (requesting),
    .ptr   (ptr_r),
    .mode  (ARB_MODE),
    .grant (pick)
  );

  // One-hot AND-OR mux of the winning port's request fields.
  always_comb begin
    sel_addr  = '0;
    sel_type  = '0;
    sel_wdata = '0;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_addr  |= req_addr_i[i] & {ADDR_W{pick[i]}};
      sel_type  |= req_data_type_i[i] & {TYPE_W{pick[i]}};
      sel_wdata |= req_wr_data_i[i] & {LINE_W{pick[i]}};
      sel_rd    |= req_rd_i[i] & pick[i];
      sel_wr    |= req_wr_i[i] & pick[i];
    end
  end

  // Index of the current owner and the round-robin origin that follows it.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      g_idx |= grant_r[i] ? PTR_W'(i) : '0;
    end
    if (g_idx == PTR_W'(NUM_PORTS - 1)) begin
      ptr_after = '0;
    end else begin
      ptr_after = g_idx + PTR_W'(1'b1);
    end
  end

  // Next-state and next-value logic for the transaction FSM.
  always_comb begin
    state_nxt = state_r;
    ptr_nxt   = ptr_r;
    cnt_nxt   = cnt_r;
    grant_nxt = grant_r;
    addr_nxt  = addr_r;
    rd_nxt    = rd_r;
    wr_nxt    = wr_r;
    type_nxt  = type_r;
    wdata_nxt = wdata_r;
    case (state_r)
      IDLE: begin
        cnt_nxt = '0;
        if (|requesting) begin
          state_nxt = BUSY;
          grant_nxt = pick;
          addr_nxt  = sel_addr;
          type_nxt  = memop_data_type_e'(sel_type);
          wdata_nxt = sel_wdata;
          wr_nxt    = sel_wr;
          rd_nxt    = sel_rd & ~sel_wr;
        end else begin
          grant_nxt = '0;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
        end
      end
      BUSY: begin
        if (mem_ready_i) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          ptr_nxt   = ptr_after;
        end else if (cnt_r < CNT_MAX) begin
          cnt_nxt = cnt_r + CNT_W'(1'b1);
        end else begin
          cnt_nxt = cnt_r;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
      end
    endcase
    timeout_nxt = timeout_r | (TMO_EN & (cnt_nxt == CNT_MAX));
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      cnt_r     <= '0;
      timeout_r <= 1'b0;
      grant_r   <= '0;
      addr_r    <= '0;
      rd_r      <= 1'b0;
      wr_r      <= 1'b0;
      type_r    <= WORD;
      wdata_r   <= '0;
    end else begin
      state_r   <= state_nxt;
      ptr_r     <= ptr_nxt;
      cnt_r     <= cnt_nxt;
      timeout_r <= timeout_nxt;
      grant_r   <= grant_nxt;
      addr_r    <= addr_nxt;
      rd_r      <= rd_nxt;
      wr_r      <= wr_nxt;
      type_r    <= type_nxt;
      wdata_r   <= wdata_nxt;
    end
  end

  // Completion strobe is combinational so the owner sees it in the ready cycle.
  assign req_ready_o     = (state_r == BUSY) ? (grant_r & {NUM_PORTS{mem_ready_i}}) : '0;
  assign req_rd_data_o   = mem_rd_data_i;
  assign grant_o         = grant_r;
  assign busy_o          = (state_r == BUSY);
  assign timeout_o       = timeout_r;
  assign mem_addr_o      = addr_r;
  assign mem_rd_o        = rd_r;
  assign mem_wr_o        = wr_r;
  assign mem_data_type_o = type_r;
  assign mem_wr_data_o   = wdata_r;

endmodule
